// File: rtl/div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed operands are converted to magnitudes up front and the sign fix happens in FIN.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_W   = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sel_rem_q, sel_rem_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_neg_s, b_neg_s, ovf_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

    // Operand preparation, one division step and the final sign fix
    always_comb begin
        a_neg_s   = ~op[0] & a[WIDTH-1];
        b_neg_s   = ~op[0] & b[WIDTH-1];
        a_mag_s   = a_neg_s ? (~a + ONE) : a;
        b_mag_s   = b_neg_s ? (~b + ONE) : b;
        ovf_s     = ~op[0] & (a == MIN_NEG) & (b == ONES);
        rem_sh_s  = {rem_q, quo_q[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, dvs_q};
        quo_fix_s = quo_neg_q ? (~quo_q + ONE) : quo_q;
        rem_fix_s = rem_neg_q ? (~rem_q + ONE) : rem_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                // The done cycle is also an IDLE cycle, so a start there is dropped
                if (start && !done_q) begin
                    busy_d    = 1'b1;
                    sel_rem_d = op[1];
                    if (b == ZERO) begin
                        quo_d     = ONES;
                        rem_d     = a;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = FIN;
                    end else if (ovf_s) begin
                        quo_d     = a;
                        rem_d     = ZERO;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = FIN;
                    end else begin
                        quo_d     = a_mag_s;
                        rem_d     = ZERO;
                        dvs_d     = b_mag_s;
                        quo_neg_d = a_neg_s ^ b_neg_s;
                        rem_neg_d = a_neg_s;
                        cnt_d     = CNT_W;
                        state_d   = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - CNT_ONE;
                quo_d  = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
                if (diff_s[WIDTH]) begin
                    rem_d = rem_sh_s[WIDTH-1:0];
                end else begin
                    rem_d = diff_s[WIDTH-1:0];
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                end
            end
            FIN: begin
                done_d   = 1'b1;
                result_d = sel_rem_q ? rem_fix_s : quo_fix_s;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            quo_q     <= ZERO;
            rem_q     <= ZERO;
            dvs_q     <= ZERO;
            sel_rem_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
